// File: rtl/fifo_word_serializer.sv
// Drains WIDTH-bit words from a shift-register FIFO and emits each one as
// WIDTH/OUT_WIDTH narrower beats on a valid/ready stream, back-to-back across words.
module fifo_word_serializer #(
  parameter int WIDTH     = 64,
  parameter int OUT_WIDTH = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 res_n,
  input  logic                 fifo_empty,
  input  logic [WIDTH-1:0]     fifo_data,
  output logic                 fifo_shift_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_last,
  output logic                 busy
);

  localparam int N     = WIDTH / OUT_WIDTH;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] sreg_q;
  logic [WIDTH-1:0] sreg_shifted;
  logic             accept;

  // Handshake: a beat transfers on a rising edge where out_valid && out_ready;
  // out_valid stays high and out_data/out_last stay stable until that happens.
  assign out_valid = (state_q == SEND);
  assign busy      = (state_q == SEND);
  assign out_last  = (state_q == SEND) && (cnt_q == LAST_CNT);
  assign accept    = out_valid && out_ready;

  // Pop whenever nothing is held, or the held word's final beat leaves this edge.
  assign fifo_shift_out = res_n && !fifo_empty &&
                          ((state_q == IDLE) || (accept && out_last));

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign out_data     = sreg_q[WIDTH-1 -: OUT_WIDTH];
      assign sreg_shifted = sreg_q << OUT_WIDTH;
    end else begin : g_lsb_first
      assign out_data     = sreg_q[OUT_WIDTH-1:0];
      assign sreg_shifted = sreg_q >> OUT_WIDTH;
    end
  endgenerate

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sreg_q  <= '0;
    end else if (fifo_shift_out) begin
      state_q <= SEND;
      cnt_q   <= '0;
      sreg_q  <= fifo_data;
    end else if (accept) begin
      if (out_last) begin
        state_q <= IDLE;
      end else begin
        cnt_q  <= cnt_q + CNT_W'(1);
        sreg_q <= sreg_shifted;
      end
    end
  end

endmodule

// File: tb/tb_fifo_word_serializer.sv
// Directed bench: a queue-based FIFO model feeds an MSB-first and an LSB-first
// serializer in lockstep; a scoreboard of expected beats checks both streams.
module tb_fifo_word_serializer;

  localparam int W  = 64;
  localparam int OW = 8;
  localparam int N  = W / OW;
  localparam logic [W-1:0] WORD_A = 64'h0123456789ABCDEF;
  localparam logic [W-1:0] JUNK   = 64'hDEADBEEFCAFEF00D;

  logic          clk = 1'b0;
  logic          res_n;
  logic          fifo_empty;
  logic [W-1:0]  fifo_data;
  logic          out_ready;
  logic          shift_m, shift_l;
  logic          valid_m, valid_l;
  logic [OW-1:0] data_m, data_l;
  logic          last_m, last_l;
  logic          busy_m, busy_l;

  logic [W-1:0]  fifo_q[$];
  logic [OW-1:0] exp_m_q[$];
  logic [OW-1:0] exp_l_q[$];
  logic          exp_last_q[$];

  int checks   = 0;
  int failures = 0;
  int pop_cnt  = 0;
  int acc_cnt  = 0;
  int cyc      = 0;
  int first_valid_cyc = -1;
  int last_acc_cyc    = -1;
  logic [W-1:0] pack_m, pack_l;

  always #5 clk = ~clk;

  fifo_word_serializer #(.WIDTH(W), .OUT_WIDTH(OW), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .res_n(res_n), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_shift_out(shift_m), .out_valid(valid_m), .out_ready(out_ready),
    .out_data(data_m), .out_last(last_m), .busy(busy_m)
  );

  fifo_word_serializer #(.WIDTH(W), .OUT_WIDTH(OW), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .res_n(res_n), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_shift_out(shift_l), .out_valid(valid_l), .out_ready(out_ready),
    .out_data(data_l), .out_last(last_l), .busy(busy_l)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_fifo();
    fifo_empty = (fifo_q.size() == 0);
    fifo_data  = fifo_empty ? JUNK : fifo_q[0];
  endtask

  task automatic flush_exp();
    exp_m_q.delete();
    exp_l_q.delete();
    exp_last_q.delete();
  endtask

  // One clock cycle: check outputs on the falling edge, then update the FIFO model.
  task automatic step(input logic rdy);
    logic         popped;
    logic         exp_pop;
    logic [W-1:0] w;
    out_ready = rdy;
    @(negedge clk);
    cyc++;
    exp_pop = res_n && (fifo_q.size() != 0) &&
              ((exp_m_q.size() == 0) || (rdy && exp_m_q.size() == 1));
    chk("shift_out_msb", W'(shift_m), W'(exp_pop));
    chk("shift_out_lsb", W'(shift_l), W'(exp_pop));
    chk("valid_msb", W'(valid_m), W'(exp_m_q.size() != 0));
    chk("valid_lsb", W'(valid_l), W'(exp_m_q.size() != 0));
    chk("busy_msb", W'(busy_m), W'(exp_m_q.size() != 0));
    if (exp_m_q.size() != 0) begin
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
      chk("data_msb", W'(data_m), W'(exp_m_q[0]));
      chk("data_lsb", W'(data_l), W'(exp_l_q[0]));
      chk("last_msb", W'(last_m), W'(exp_last_q[0]));
      chk("last_lsb", W'(last_l), W'(exp_last_q[0]));
      if (rdy) begin
        acc_cnt++;
        last_acc_cyc = cyc;
        pack_m = {pack_m[W-OW-1:0], data_m};
        pack_l = {data_l, pack_l[W-1:OW]};
        void'(exp_m_q.pop_front());
        void'(exp_l_q.pop_front());
        void'(exp_last_q.pop_front());
      end
    end else begin
      chk("last_idle", W'(last_m), W'(0));
    end
    popped = shift_m;
    @(posedge clk);
    #1;
    if (popped && fifo_q.size() != 0) begin
      w = fifo_q.pop_front();
      pop_cnt++;
      for (int i = 0; i < N; i++) begin
        exp_m_q.push_back(w[W-1-i*OW -: OW]);
        exp_l_q.push_back(w[i*OW +: OW]);
        exp_last_q.push_back(i == N - 1);
      end
    end
    drive_fifo();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_m_q.size() != 0 || fifo_q.size() != 0) && n < budget) begin
      step(1'b1);
      n++;
    end
    chk("drain_timeout", W'(exp_m_q.size() != 0 || fifo_q.size() != 0), W'(0));
  endtask

  task automatic clear_stats();
    pop_cnt = 0; acc_cnt = 0; first_valid_cyc = -1; last_acc_cyc = -1;
    pack_m = '0; pack_l = '0;
  endtask

  initial begin
    res_n     = 1'b0;
    out_ready = 1'b1;
    pack_m    = '0;
    pack_l    = '0;
    fifo_q.push_back(WORD_A);
    drive_fifo();

    // Reset held with a word waiting: no pop, no valid.
    for (int i = 0; i < 3; i++) step(1'b1);
    chk("t1_no_pop_in_reset", W'(pop_cnt), W'(0));
    res_n = 1'b1;
    clear_stats();
    step(1'b1);
    chk("t1_pop_first_edge", W'(pop_cnt), W'(1));

    // Single known word drains in 8 consecutive cycles, both orders.
    drain(20);
    step(1'b1);
    chk("t2_single_pop", W'(pop_cnt), W'(1));
    chk("t2_beats", W'(acc_cnt), W'(N));
    chk("t2_msb_order", pack_m, WORD_A);
    chk("t2_lsb_order", pack_l, WORD_A);
    chk("t2_first_lsb_beat_pos", W'(pack_l[OW-1:0]), W'(8'hEF));
    chk("t2_consecutive", W'(last_acc_cyc - first_valid_cyc + 1), W'(N));

    // Two words back-to-back: 16 beats with no gap.
    clear_stats();
    fifo_q.push_back({$urandom, $urandom});
    fifo_q.push_back({$urandom, $urandom});
    drive_fifo();
    drain(40);
    chk("t3_pops", W'(pop_cnt), W'(2));
    chk("t3_beats", W'(acc_cnt), W'(2 * N));
    chk("t3_no_gap", W'(last_acc_cyc - first_valid_cyc + 1), W'(2 * N));

    // Alternating backpressure: 8 beats over 16 cycles, order preserved.
    clear_stats();
    fifo_q.push_back(WORD_A);
    drive_fifo();
    step(1'b1);
    for (int i = 0; i < 2 * N; i++) step((i % 2) == 0);
    chk("t4_beats", W'(acc_cnt), W'(N));
    chk("t4_msb_order", pack_m, WORD_A);
    chk("t4_lsb_order", pack_l, WORD_A);
    chk("t4_done", W'(exp_m_q.size()), W'(0));

    // Reset after 3 accepted beats discards the rest; next word starts fresh.
    clear_stats();
    fifo_q.push_back({$urandom, $urandom});
    fifo_q.push_back(WORD_A);
    drive_fifo();
    for (int i = 0; i < 4; i++) step(1'b1);
    chk("t6_three_beats", W'(acc_cnt), W'(3));
    res_n = 1'b0;
    #1;
    chk("t6_rst_valid", W'(valid_m), W'(0));
    chk("t6_rst_busy", W'(busy_l), W'(0));
    chk("t6_rst_shift", W'(shift_m), W'(0));
    chk("t6_rst_data", W'(data_m), W'(0));
    chk("t6_rst_last", W'(last_m), W'(0));
    flush_exp();
    for (int i = 0; i < 2; i++) step(1'b1);
    chk("t6_fifo_untouched", W'(fifo_q.size()), W'(1));
    res_n = 1'b1;
    clear_stats();
    drain(20);
    chk("t6_next_word_msb", pack_m, WORD_A);
    chk("t6_next_word_lsb", pack_l, WORD_A);
    step(1'b0);
    step(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
